// File: rtl/picorv32_axil_bridge.sv
// Bridges the PicoRV32 native memory interface onto an AXI4-lite master.
// Adds a response timeout with late-response draining and a sticky bus-error report.
module picorv32_axil_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1023,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rsi_reset,

    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,

    output logic                  axm_awvalid,
    input  logic                  axm_awready,
    output logic [ADDR_WIDTH-1:0] axm_awaddr,
    output logic [2:0]            axm_awprot,
    output logic                  axm_wvalid,
    input  logic                  axm_wready,
    output logic [31:0]           axm_wdata,
    output logic [3:0]            axm_wstrb,
    input  logic                  axm_bvalid,
    input  logic [1:0]            axm_bresp,
    output logic                  axm_bready,

    output logic                  axm_arvalid,
    input  logic                  axm_arready,
    output logic [ADDR_WIDTH-1:0] axm_araddr,
    output logic [2:0]            axm_arprot,
    input  logic                  axm_rvalid,
    input  logic [1:0]            axm_rresp,
    output logic                  axm_rready,
    input  logic [31:0]           axm_rdata,

    output logic                  coe_err_irq,
    output logic [31:0]           coe_err_addr,
    output logic [1:0]            coe_err_code,
    input  logic                  inr_err_clr
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      req_addr;
    logic             timed_out;
    logic             timeout_hit;
    logic             aw_pend;
    logic             w_pend;
    logic [1:0]       err_bits;

    assign axm_awprot = 3'b000;

    // Error events and channel bookkeeping for the current cycle
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
        aw_pend     = axm_awvalid && !axm_awready;
        w_pend      = axm_wvalid && !axm_wready;
        err_bits    = 2'b00;
        if (state == WRESP) begin
            if (axm_bvalid)
                err_bits[0] = (axm_bresp != 2'b00);
            else if (timeout_hit)
                err_bits[1] = 1'b1;
        end
        if (state == RDATA) begin
            if (axm_rvalid)
                err_bits[0] = (axm_rresp != 2'b00);
            else if (timeout_hit)
                err_bits[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rsi_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_addr    <= '0;
            timed_out   <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            axm_awvalid <= 1'b0;
            axm_awaddr  <= '0;
            axm_wvalid  <= 1'b0;
            axm_wdata   <= '0;
            axm_wstrb   <= '0;
            axm_bready  <= 1'b0;
            axm_arvalid <= 1'b0;
            axm_araddr  <= '0;
            axm_arprot  <= '0;
            axm_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        req_addr   <= mem_addr;
                        axm_awaddr <= mem_addr[ADDR_WIDTH-1:0];
                        axm_araddr <= mem_addr[ADDR_WIDTH-1:0];
                        axm_arprot <= {mem_instr, 2'b00};
                        axm_wdata  <= mem_wdata;
                        axm_wstrb  <= mem_wstrb;
                        if (mem_wstrb != 4'b0000) begin
                            axm_awvalid <= 1'b1;
                            axm_wvalid  <= 1'b1;
                            state       <= WADDR;
                        end else begin
                            axm_arvalid <= 1'b1;
                            state       <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (axm_awready) axm_awvalid <= 1'b0;
                    if (axm_wready)  axm_wvalid  <= 1'b0;
                    if (!aw_pend && !w_pend) begin
                        axm_bready <= 1'b1;
                        cnt        <= '0;
                        state      <= WRESP;
                    end
                end
                WRESP: begin
                    if (axm_bvalid || timeout_hit) begin
                        axm_bready <= 1'b0;
                        mem_ready  <= 1'b1;
                        mem_rdata  <= '0;
                        timed_out  <= !axm_bvalid;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RADDR: begin
                    if (axm_arready) begin
                        axm_arvalid <= 1'b0;
                        axm_rready  <= 1'b1;
                        cnt         <= '0;
                        state       <= RDATA;
                    end
                end
                RDATA: begin
                    if (axm_rvalid || timeout_hit) begin
                        axm_rready <= 1'b0;
                        mem_ready  <= 1'b1;
                        mem_rdata  <= axm_rvalid ? axm_rdata : ERR_RDATA;
                        timed_out  <= !axm_rvalid;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    mem_ready <= 1'b0;
                    timed_out <= 1'b0;
                    // A timed-out transaction still owes the slave one response
                    if (timed_out) begin
                        axm_bready <= 1'b1;
                        axm_rready <= 1'b1;
                        state      <= DRAIN;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if ((axm_bvalid && axm_bready) || (axm_rvalid && axm_rready)) begin
                        axm_bready <= 1'b0;
                        axm_rready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error report; a new error in the clear cycle wins and reloads the address
    always_ff @(posedge clk) begin
        if (rsi_reset) begin
            coe_err_irq  <= 1'b0;
            coe_err_addr <= '0;
            coe_err_code <= '0;
        end else if (err_bits != 2'b00) begin
            coe_err_irq <= 1'b1;
            if (!coe_err_irq || inr_err_clr) begin
                coe_err_addr <= req_addr;
                coe_err_code <= err_bits;
            end else begin
                coe_err_code <= coe_err_code | err_bits;
            end
        end else if (inr_err_clr) begin
            coe_err_irq  <= 1'b0;
            coe_err_code <= '0;
        end
    end

endmodule

// File: tb/tb_picorv32_axil_bridge.sv
// Directed table-driven bench for picorv32_axil_bridge with a small reactive AXI4-lite slave.
module tb_picorv32_axil_bridge;

    logic        clk;
    logic        rsi_reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        axm_awvalid;
    logic        axm_awready;
    logic [15:0] axm_awaddr;
    logic [2:0]  axm_awprot;
    logic        axm_wvalid;
    logic        axm_wready;
    logic [31:0] axm_wdata;
    logic [3:0]  axm_wstrb;
    logic        axm_bvalid;
    logic [1:0]  axm_bresp;
    logic        axm_bready;
    logic        axm_arvalid;
    logic        axm_arready;
    logic [15:0] axm_araddr;
    logic [2:0]  axm_arprot;
    logic        axm_rvalid;
    logic [1:0]  axm_rresp;
    logic        axm_rready;
    logic [31:0] axm_rdata;
    logic        coe_err_irq;
    logic [31:0] coe_err_addr;
    logic [1:0]  coe_err_code;
    logic        inr_err_clr;

    int checks = 0;
    int errors = 0;

    picorv32_axil_bridge #(.ADDR_WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rsi_reset(rsi_reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .axm_awvalid(axm_awvalid), .axm_awready(axm_awready), .axm_awaddr(axm_awaddr),
        .axm_awprot(axm_awprot), .axm_wvalid(axm_wvalid), .axm_wready(axm_wready),
        .axm_wdata(axm_wdata), .axm_wstrb(axm_wstrb), .axm_bvalid(axm_bvalid),
        .axm_bresp(axm_bresp), .axm_bready(axm_bready),
        .axm_arvalid(axm_arvalid), .axm_arready(axm_arready), .axm_araddr(axm_araddr),
        .axm_arprot(axm_arprot), .axm_rvalid(axm_rvalid), .axm_rresp(axm_rresp),
        .axm_rready(axm_rready), .axm_rdata(axm_rdata),
        .coe_err_irq(coe_err_irq), .coe_err_addr(coe_err_addr), .coe_err_code(coe_err_code),
        .inr_err_clr(inr_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          instr;
        int          da;        // ready delay on AW/AR
        int          dw;        // ready delay on W
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          no_resp;
        int          clr_cyc;   // cycle to pulse inr_err_clr, 0 = none
        int          exp_cyc;   // cycle of mem_ready, mem_valid raised in cycle 0
        logic [31:0] exp_rdata;
        logic [15:0] exp_axaddr;
        logic [2:0]  exp_prot;
        int          exp_a;     // cycles AW/AR valid is high
        int          exp_w;     // cycles W valid is high
        bit          exp_irq;
        logic [1:0]  exp_code;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t tbl[7];
    vec_t v_to, v_stall, v_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int rdy_cyc = -1;
        int rdy_cnt = 0;
        int a_cnt = 0;
        int w_cnt = 0;
        bit stable = 1'b1;
        logic [31:0] got = '0;
        mem_valid = 1'b1;
        mem_instr = v.instr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        for (int k = 0; k < 45; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            inr_err_clr = (v.clr_cyc != 0) && (k == v.clr_cyc);
            if (axm_awvalid) begin
                a_cnt++;
                if (axm_awaddr !== v.exp_axaddr || axm_awprot !== 3'b000) stable = 1'b0;
                axm_awready = (a_cnt > v.da);
            end else begin
                axm_awready = 1'b0;
            end
            if (axm_wvalid) begin
                w_cnt++;
                if (axm_wdata !== v.wdata || axm_wstrb !== v.wstrb) stable = 1'b0;
                axm_wready = (w_cnt > v.dw);
            end else begin
                axm_wready = 1'b0;
            end
            if (axm_arvalid) begin
                a_cnt++;
                if (axm_araddr !== v.exp_axaddr || axm_arprot !== v.exp_prot) stable = 1'b0;
                axm_arready = (a_cnt > v.da);
            end else begin
                axm_arready = 1'b0;
            end
            axm_bvalid = axm_bready && !v.no_resp;
            axm_bresp  = (a_cnt > 0) ? v.resp : 2'b00;
            axm_rvalid = axm_rready && !v.no_resp;
            axm_rresp  = (a_cnt > 0) ? v.resp : 2'b00;
            axm_rdata  = (a_cnt > 0) ? v.rdata : 32'hBAD0_BAD0;
            if (mem_ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = k;
                    got = mem_rdata;
                end
                mem_valid = 1'b0;
            end
            if (rdy_cyc >= 0 && k >= rdy_cyc + 2) break;
        end
        inr_err_clr = 1'b0;
        check({tag, " ready_cycle"}, 32'(rdy_cyc), 32'(v.exp_cyc));
        check({tag, " ready_pulses"}, 32'(rdy_cnt), 32'd1);
        check({tag, " mem_rdata"}, got, v.exp_rdata);
        check({tag, " channel_stable"}, 32'(stable), 32'd1);
        check({tag, " addr_valid_cycles"}, 32'(a_cnt), 32'(v.exp_a));
        if (v.is_wr) check({tag, " wvalid_cycles"}, 32'(w_cnt), 32'(v.exp_w));
        check({tag, " err_irq"}, 32'(coe_err_irq), 32'(v.exp_irq));
        check({tag, " err_code"}, 32'(coe_err_code), 32'(v.exp_code));
        if (v.exp_irq) check({tag, " err_addr"}, coe_err_addr, v.exp_eaddr);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " awvalid"}, 32'(axm_awvalid), 32'd0);
        check({tag, " wvalid"}, 32'(axm_wvalid), 32'd0);
        check({tag, " arvalid"}, 32'(axm_arvalid), 32'd0);
        check({tag, " bready"}, 32'(axm_bready), 32'd0);
        check({tag, " rready"}, 32'(axm_rready), 32'd0);
        check({tag, " mem_ready"}, 32'(mem_ready), 32'd0);
        check({tag, " mem_rdata"}, mem_rdata, 32'd0);
        check({tag, " err_irq"}, 32'(coe_err_irq), 32'd0);
        check({tag, " err_code"}, 32'(coe_err_code), 32'd0);
        check({tag, " err_addr"}, coe_err_addr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr addr            wdata          wstrb  in da dw resp   rdata          nr clr cyc exp_rdata      axaddr    prot    a  w irq code   eaddr
        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0,  1'b0, 0, 0, 2'b00, 32'h1234_5678, 1'b0, 0, 3, 32'h1234_5678, 16'h0100, 3'b000, 1, 0, 1'b0, 2'b00, 32'h0};
        tbl[1] = '{1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 4'h3,  1'b0, 3, 0, 2'b00, 32'h0,         1'b0, 0, 6, 32'h0,         16'h0040, 3'b000, 4, 1, 1'b0, 2'b00, 32'h0};
        tbl[2] = '{1'b0, 32'h0001_ABCC, 32'h0,         4'h0,  1'b1, 0, 0, 2'b00, 32'hCAFE_F00D, 1'b0, 0, 3, 32'hCAFE_F00D, 16'hABCC, 3'b100, 1, 0, 1'b0, 2'b00, 32'h0};
        tbl[3] = '{1'b1, 32'h0000_0008, 32'h0123_4567, 4'hF,  1'b0, 0, 2, 2'b00, 32'h0,         1'b0, 0, 5, 32'h0,         16'h0008, 3'b000, 1, 3, 1'b0, 2'b00, 32'h0};
        tbl[4] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0,  1'b0, 0, 0, 2'b10, 32'h1111_1111, 1'b0, 0, 3, 32'h1111_1111, 16'h2000, 3'b000, 1, 0, 1'b1, 2'b01, 32'h2000};
        tbl[5] = '{1'b1, 32'h0000_3000, 32'hFFFF_0000, 4'hC,  1'b0, 1, 1, 2'b11, 32'h0,         1'b0, 0, 4, 32'h0,         16'h3000, 3'b000, 2, 2, 1'b1, 2'b01, 32'h2000};
        tbl[6] = '{1'b0, 32'h0000_4000, 32'h0,         4'h0,  1'b0, 0, 0, 2'b10, 32'h2222_2222, 1'b0, 2, 3, 32'h2222_2222, 16'h4000, 3'b000, 1, 0, 1'b1, 2'b01, 32'h4000};
        v_to    = '{1'b0, 32'h0001_0500, 32'h0, 4'h0, 1'b0, 0, 0, 2'b00, 32'h0,         1'b1, 0, 11, 32'hDEAD_BEEF, 16'h0500, 3'b000, 1, 0, 1'b1, 2'b10, 32'h0001_0500};
        v_stall = '{1'b0, 32'h0000_0600, 32'h0, 4'h0, 1'b0, 0, 0, 2'b00, 32'h600D_600D, 1'b0, 0, 4, 32'h600D_600D, 16'h0600, 3'b000, 1, 0, 1'b1, 2'b10, 32'h0001_0500};
        v_rst   = '{1'b0, 32'h0000_0700, 32'h0, 4'h0, 1'b0, 0, 0, 2'b00, 32'h3333_3333, 1'b0, 0, 3, 32'h3333_3333, 16'h0700, 3'b000, 1, 0, 1'b0, 2'b00, 32'h0};

        rsi_reset = 1'b1;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        axm_awready = 1'b0; axm_wready = 1'b0; axm_bvalid = 1'b0; axm_bresp = '0;
        axm_arready = 1'b0; axm_rvalid = 1'b0; axm_rresp = '0; axm_rdata = '0;
        inr_err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rsi_reset = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Clear pulse with no concurrent error
        inr_err_clr = 1'b1;
        @(posedge clk);
        #1;
        inr_err_clr = 1'b0;
        check("clr irq", 32'(coe_err_irq), 32'd0);
        check("clr code", 32'(coe_err_code), 32'd0);

        // Timeout, then a second request must wait for the late response to be drained
        run_txn(v_to, "timeout");
        mem_valid = 1'b1;
        mem_addr  = v_stall.addr;
        mem_wstrb = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("drain_stall%0d arvalid", k), 32'(axm_arvalid), 32'd0);
            check($sformatf("drain_stall%0d mem_ready", k), 32'(mem_ready), 32'd0);
            check($sformatf("drain_stall%0d rready", k), 32'(axm_rready), 32'd1);
        end
        run_txn(v_stall, "after_drain");

        // Reset in the middle of a write address phase
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0800;
        mem_wdata = 32'h5555_AAAA;
        mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        check("pre_reset awvalid", 32'(axm_awvalid), 32'd1);
        check("pre_reset wvalid", 32'(axm_wvalid), 32'd1);
        rsi_reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset");
        rsi_reset = 1'b0;
        mem_valid = 1'b0;
        run_txn(v_rst, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
